// File: rtl/student_deser8_pkg.sv
// student_deser8_pkg
//   Shared widths and the byte type used by the serial-to-parallel front end
//   and the 8-way OR reduction stage.
package student_deser8_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/student_or8way.sv
// student_or8way
//   8-way OR reduction of a byte.
//   Ports:
//     in_word  in   8  byte to reduce
//     out      out  1  high when any bit of in_word is set
module student_or8way
    import student_deser8_pkg::*;
(
    input  word_t in_word,
    output logic  out
);

    assign out = |in_word;

endmodule

// File: rtl/student_deser8.sv
// student_deser8
//   Collects 8 serial bits into a byte and presents it through a one-entry
//   valid/ready output buffer, with an activity flag from student_or8way.
//   Ports:
//     clk        in   1  system clock, rising edge
//     reset      in   1  asynchronous, active-high reset
//     in_bit     in   1  serial data bit
//     in_valid   in   1  in_bit offered this cycle
//     in_ready   out  1  in_bit accepted this cycle
//     out_word   out  8  buffered byte
//     out_valid  out  1  out_word holds an unconsumed byte
//     out_ready  in   1  consumer takes out_word this cycle
//     out_any    out  1  out_valid AND or8way(out_word)
//     bit_count  out  3  bits held in the partial shift register
//   Parameter MSB_FIRST: 1 puts the first accepted bit in out_word[7],
//   0 puts it in out_word[0].
//
//   Operating modes, derived from bit_count/out_valid (no state register):
//     state        | meaning
//     COLLECT      | out_valid = 0, gathering bits
//     HOLD_COLLECT | out_valid = 1, bit_count < 7, gathering behind a full buffer
//     STALL        | out_valid = 1, bit_count = 7, out_ready = 0, last bit held off
module student_deser8
    import student_deser8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output word_t            out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    word_t shreg;
    word_t assembled;
    logic  accept;
    logic  complete;
    logic  drain;
    logic  any_raw;

    // Only the completing bit can stall; earlier bits never touch the buffer.
    assign in_ready = !((bit_count == LAST_BIT) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (bit_count == LAST_BIT);
    assign drain    = out_valid && out_ready;

    // Shift register contents including the bit being accepted now.
    always_comb begin
        assembled = shreg;
        if (MSB_FIRST) begin
            assembled = {shreg[WORD_W-2:0], in_bit};
        end else begin
            assembled = {in_bit, shreg[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_count <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                bit_count <= bit_count + 3'd1;
                if (complete) begin
                    shreg    <= '0;
                    out_word <= assembled;
                end else begin
                    shreg <= assembled;
                end
            end
            // A completion in the same cycle as a drain keeps out_valid high.
            if (complete) begin
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    student_or8way u_or8way (
        .in_word (out_word),
        .out     (any_raw)
    );

    assign out_any = out_valid && any_raw;

endmodule

// File: tb/tb_student_deser8.sv
module tb_student_deser8;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;

    logic       m_ready, m_valid, m_any;
    logic [7:0] m_word;
    logic [2:0] m_cnt;
    logic       l_ready, l_valid, l_any;
    logic [7:0] l_word;
    logic [2:0] l_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state and scoreboards (MSB-first and LSB-first results)
    int         mdl_cnt;
    bit         mdl_ov;
    logic [7:0] mdl_m, mdl_l;
    logic [7:0] qm[$];
    logic [7:0] ql[$];

    student_deser8 #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(m_ready), .out_word(m_word), .out_valid(m_valid),
        .out_ready(out_ready), .out_any(m_any), .bit_count(m_cnt)
    );

    student_deser8 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(l_ready), .out_word(l_word), .out_valid(l_valid),
        .out_ready(out_ready), .out_any(l_any), .bit_count(l_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mdl_cnt = 0;
        mdl_ov  = 1'b0;
        mdl_m   = 8'h00;
        mdl_l   = 8'h00;
        qm.delete();
        ql.delete();
    endtask

    // One rising edge; the model follows the same handshake and pushes the
    // expected bytes when a word completes. Returns 1 ns after the edge.
    task automatic do_edge();
        bit         acc;
        logic [7:0] nm, nl;
        @(posedge clk);
        acc = in_valid && !(mdl_cnt == 7 && mdl_ov && !out_ready);
        if (mdl_ov && out_ready) mdl_ov = 1'b0;
        if (acc) begin
            nm = {mdl_m[6:0], in_bit};
            nl = {in_bit, mdl_l[7:1]};
            if (mdl_cnt == 7) begin
                qm.push_back(nm);
                ql.push_back(nl);
                mdl_ov  = 1'b1;
                mdl_m   = 8'h00;
                mdl_l   = 8'h00;
                mdl_cnt = 0;
            end else begin
                mdl_m   = nm;
                mdl_l   = nl;
                mdl_cnt = mdl_cnt + 1;
            end
        end
        #1;
    endtask

    // Sends seq[7] first down to seq[0], one bit per edge.
    task automatic send_byte(input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) begin
            in_valid = 1'b1;
            in_bit   = seq[i];
            do_edge();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic pop_exp(output logic [7:0] em, output logic [7:0] el, output bit ok);
        ok = (qm.size() > 0) && (ql.size() > 0);
        em = 8'hxx;
        el = 8'hxx;
        if (ok) begin
            em = qm.pop_front();
            el = ql.pop_front();
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (m_word !== 8'h00) begin failures++; $display("FAIL reset_word got=%h exp=00", m_word); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_any !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", m_any); end
        checks++; if (m_cnt !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", m_cnt); end
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", m_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        // three bits, then reset between edges
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bit   = i[0];
            do_edge();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_cnt !== 3'd3) begin failures++; $display("FAIL midword_count got=%0d exp=3", m_cnt); end
        #1 reset = 1'b1;
        #1;
        checks++; if (m_cnt !== 3'd0 || l_cnt !== 3'd0) begin failures++; $display("FAIL async_reset_count got=%0d/%0d exp=0", m_cnt, l_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_msb_basic();
        logic [7:0] em, el;
        bit         ok;
        out_ready = 1'b1;
        send_byte(8'b00100110);
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        checks++; if (m_any !== 1'b1) begin failures++; $display("FAIL basic_any got=%b exp=1", m_any); end
        checks++; if (m_word !== 8'b00100110) begin failures++; $display("FAIL basic_word got=%b exp=00100110", m_word); end
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL basic_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
        do_edge();
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", m_valid); end
    endtask

    task automatic test_zero_ones();
        logic [7:0] em, el;
        bit         ok;
        out_ready = 1'b1;
        send_byte(8'h00);
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL zeros_valid got=%b exp=1", m_valid); end
        checks++; if (m_any !== 1'b0 || l_any !== 1'b0) begin failures++; $display("FAIL zeros_any got=%b/%b exp=0", m_any, l_any); end
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL zeros_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
        send_byte(8'hFF);
        @(negedge clk);
        checks++; if (m_word !== 8'hFF) begin failures++; $display("FAIL ones_word got=%h exp=ff", m_word); end
        checks++; if (m_any !== 1'b1) begin failures++; $display("FAIL ones_any got=%b exp=1", m_any); end
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL ones_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
        do_edge();
    endtask

    task automatic test_backpressure();
        logic [7:0] em, el;
        bit         ok;
        out_ready = 1'b0;
        send_byte(8'b00010000);
        @(negedge clk);
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el || m_valid !== 1'b1) begin failures++; $display("FAIL bp_first_sb got=%h/%h v=%b exp=%h/%h v=1", m_word, l_word, m_valid, em, el); end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b0;
            do_edge();
        end
        in_bit = 1'b1;
        @(negedge clk);
        checks++; if (m_cnt !== 3'd7) begin failures++; $display("FAIL bp_count got=%0d exp=7", m_cnt); end
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", m_ready); end
        do_edge();
        @(negedge clk);
        checks++; if (m_cnt !== 3'd7 || m_word !== 8'h10) begin failures++; $display("FAIL bp_held got=%0d/%h exp=7/10", m_cnt, m_word); end
        out_ready = 1'b1;
        #1;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", m_ready); end
        do_edge();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_no_bubble got=%b exp=1", m_valid); end
        checks++; if (m_word !== 8'h01) begin failures++; $display("FAIL bp_second_word got=%h exp=01", m_word); end
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL bp_second_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
        do_edge();
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || m_any !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b/%b exp=0/0", m_valid, m_any); end
        checks++; if (m_word !== 8'h01) begin failures++; $display("FAIL bp_word_kept got=%h exp=01", m_word); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] em, el;
        bit         ok;
        out_ready = 1'b1;
        send_byte(8'b10000000);
        @(negedge clk);
        checks++; if (l_word !== 8'h01) begin failures++; $display("FAIL lsb_word got=%h exp=01", l_word); end
        checks++; if (l_any !== 1'b1 || l_valid !== 1'b1) begin failures++; $display("FAIL lsb_any got=%b/%b exp=1/1", l_any, l_valid); end
        pop_exp(em, el, ok);
        checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL lsb_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
        do_edge();
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [7:0]  em, el;
        bit          ok;
        int          pulses[$];
        int          stalls;
        stream    = 16'hA53C;
        stalls    = 0;
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            in_bit   = (i < 16) ? stream[15 - i] : 1'b0;
            @(negedge clk);
            if (i < 16 && m_ready !== 1'b1) stalls++;
            if (m_valid === 1'b1) begin
                pulses.push_back(i);
                pop_exp(em, el, ok);
                checks++; if (!ok || m_word !== em || l_word !== el) begin failures++; $display("FAIL b2b_sb got=%h/%h exp=%h/%h", m_word, l_word, em, el); end
            end
            do_edge();
        end
        in_valid = 1'b0;
        checks++; if (stalls !== 0) begin failures++; $display("FAIL b2b_ready_drops got=%0d exp=0", stalls); end
        checks++;
        if (pulses.size() !== 2) begin
            failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses.size());
        end else if (pulses[1] - pulses[0] !== 8) begin
            failures++; $display("FAIL b2b_pulse_gap got=%0d exp=8", pulses[1] - pulses[0]);
        end
        checks++; if (qm.size() !== 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", qm.size()); end
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_zero_ones();
        test_backpressure();
        test_lsb_first();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
